// File: rtl/seg7_pkg.sv
// Shared widths and digit-code helpers for the 7-segment scan controller.
// No timing of its own; used by the scan controller and its refresh timer.
package seg7_pkg;

  localparam int SEG_W = 7;
  localparam int BCD_W = 4;

  localparam logic [BCD_W-1:0] BLANK_CODE_MIN = 4'd10;

  // Codes 10..15 have no decimal glyph and are shown dark.
  function automatic logic is_non_bcd(input logic [BCD_W-1:0] code);
    return (code >= BLANK_CODE_MIN);
  endfunction

endpackage

// File: rtl/seg7_refresh_timer.sv
// Slot timer: counts 0..REFRESH_DIV-1 per digit slot, flags the blanking gap, seg latch point and slot end.
// Flags are combinational from the counter; free-running, no backpressure.
module seg7_refresh_timer #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_GAP   = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic gap,
  output logic latch_seg,
  output logic slot_end
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GAP   = CNT_W'(BLANK_GAP);
  localparam logic [CNT_W-1:0] CNT_LATCH = CNT_W'(BLANK_GAP - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (slot_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign gap       = (cnt < CNT_GAP);
  assign latch_seg = (cnt == CNT_LATCH);
  assign slot_end  = (cnt == CNT_LAST);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Scans a double-buffered BCD frame through one shared 7-seg decoder, one anode per slot.
// New frames show from digit 0 of the next frame; load_ready drops while a frame is pending.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_GAP   = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [BCD_W*NUM_DIGITS-1:0] load_data,
  input  logic                        blank_lz,
  output logic [BCD_W-1:0]            dec_x,
  input  logic [SEG_W-1:0]            seg_in,
  output logic [SEG_W-1:0]            seg_out,
  output logic [NUM_DIGITS-1:0]       an_n,
  output logic                        frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic gap;
  logic latch_seg;
  logic slot_end;

  seg7_refresh_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_GAP   (BLANK_GAP)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .gap       (gap),
    .latch_seg (latch_seg),
    .slot_end  (slot_end)
  );

  logic [IDX_W-1:0]            idx;
  logic [BCD_W*NUM_DIGITS-1:0] active_q;
  logic [BCD_W*NUM_DIGITS-1:0] pending_q;
  logic                        pending_vld_q;
  logic                        blank_q;

  logic                        frame_end;
  logic                        xfer;
  logic                        accept;
  logic [BCD_W-1:0]            digits [NUM_DIGITS];
  logic [BCD_W-1:0]            cur_digit;
  logic                        upper_zero;
  logic                        blank_now;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digits[gi] = active_q[gi*BCD_W +: BCD_W];
    end
  endgenerate

  assign frame_end  = slot_end && (idx == IDX_LAST);
  assign xfer       = frame_end && pending_vld_q;
  // The frame-end transfer empties the pending slot this very cycle, so a
  // held producer can refill it in the same cycle the old frame goes active.
  assign load_ready = !pending_vld_q || frame_end;
  assign accept     = load_valid && load_ready;
  assign frame_done = frame_end;

  assign cur_digit  = digits[idx];
  assign dec_x      = cur_digit;

  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((IDX_W'(i) > idx) && (digits[i] != '0)) begin
        upper_zero = 1'b0;
      end
    end
    blank_now = is_non_bcd(cur_digit) ||
                (blank_lz && (cur_digit == '0) && (idx != '0) && upper_zero);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (slot_end) begin
      idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q      <= '0;
      pending_q     <= '0;
      pending_vld_q <= 1'b0;
    end else begin
      if (xfer) begin
        active_q <= pending_q;
      end
      if (accept) begin
        pending_q <= load_data;
      end
      if (accept) begin
        pending_vld_q <= 1'b1;
      end else if (xfer) begin
        pending_vld_q <= 1'b0;
      end
    end
  end

  // Segments and the blank decision are captured together at the end of the
  // gap, so blank_lz and the decoder output are sampled once per slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out <= '0;
      blank_q <= 1'b0;
    end else if (latch_seg) begin
      seg_out <= seg_in;
      blank_q <= blank_now;
    end
  end

  always_comb begin
    an_n = '1;
    if (!gap && !blank_q) begin
      an_n[idx] = 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with a behavioural BCD decoder on dec_x/seg_in.
// Table of frames plus hand sequences for back-to-back loads and mid-slot reset.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BG = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic        blank_lz;
  logic [3:0]  dec_x;
  logic [6:0]  seg_in;
  logic [6:0]  seg_out;
  logic [3:0]  an_n;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLANK_GAP   (BG)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .blank_lz   (blank_lz),
    .dec_x      (dec_x),
    .seg_in     (seg_in),
    .seg_out    (seg_out),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  always_comb begin
    case (dec_x)
      4'd0:    seg_in = 7'b1111110;
      4'd1:    seg_in = 7'b0110000;
      4'd2:    seg_in = 7'b1101101;
      4'd3:    seg_in = 7'b1111001;
      4'd4:    seg_in = 7'b0110011;
      4'd5:    seg_in = 7'b1011011;
      4'd6:    seg_in = 7'b1011111;
      4'd7:    seg_in = 7'b1110000;
      4'd8:    seg_in = 7'b1111111;
      4'd9:    seg_in = 7'b1111011;
      default: seg_in = 7'b0000000;
    endcase
  end

  typedef struct {
    logic [15:0]     frame;
    logic            blz;
    logic [3:0][3:0] an_exp;
    logic [3:0][6:0] seg_exp;
  } vec_t;

  localparam logic [6:0] S0 = 7'h7E, S1 = 7'h30, S2 = 7'h6D, S3 = 7'h79, S4 = 7'h33;
  localparam logic [6:0] S5 = 7'h5B, S6 = 7'h5F, S7 = 7'h70, S8 = 7'h7F, S9 = 7'h7B;
  localparam logic [6:0] SX = 7'h00;

  vec_t vecs [7];
  vec_t zero_vec;
  vec_t vec_a;
  vec_t vec_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("frame_wait", {31'd0, frame_done}, 32'd1);
    tick();
  endtask

  task automatic load(input logic [15:0] d);
    int n;
    n = 0;
    load_valid = 1'b1;
    load_data  = d;
    while (load_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("load_accept", {31'd0, load_ready}, 32'd1);
    tick();
    load_valid = 1'b0;
  endtask

  // Entered at cnt 0 of slot 0; leaves at cnt 0 of slot 0 of the next frame.
  task automatic check_frame(input vec_t v, input string tag);
    int gap_err;
    int show_err;
    int dec_err;
    logic [3:0] an_first [4];
    logic [6:0] seg_first [4];
    gap_err  = 0;
    show_err = 0;
    dec_err  = 0;
    for (int s = 0; s < ND; s++) begin
      for (int c = 0; c < RD; c++) begin
        if (c == 0 && dec_x !== v.frame[4*s +: 4]) dec_err++;
        if (c < BG) begin
          if (an_n !== 4'b1111) gap_err++;
        end else if (c == BG) begin
          an_first[s]  = an_n;
          seg_first[s] = seg_out;
        end else if (an_n !== an_first[s] || seg_out !== seg_first[s]) begin
          show_err++;
        end
        tick();
      end
    end
    for (int s = 0; s < ND; s++) begin
      chk($sformatf("%s an slot%0d", tag, s), {28'd0, an_first[s]}, {28'd0, v.an_exp[s]});
      chk($sformatf("%s seg slot%0d", tag, s), {25'd0, seg_first[s]}, {25'd0, v.seg_exp[s]});
    end
    chk($sformatf("%s gap_dark", tag), gap_err, 0);
    chk($sformatf("%s show_steady", tag), show_err, 0);
    chk($sformatf("%s dec_x", tag), dec_err, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;

    zero_vec = '{frame: 16'h0000, blz: 1'b0, an_exp: {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                 seg_exp: {S0, S0, S0, S0}};
    vecs[0]  = '{frame: 16'h1234, blz: 1'b0, an_exp: {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                 seg_exp: {S1, S2, S3, S4}};
    vecs[1]  = '{frame: 16'h0050, blz: 1'b1, an_exp: {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                 seg_exp: {S0, S0, S5, S0}};
    vecs[2]  = '{frame: 16'h0000, blz: 1'b1, an_exp: {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                 seg_exp: {S0, S0, S0, S0}};
    vecs[3]  = '{frame: 16'h00A0, blz: 1'b1, an_exp: {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                 seg_exp: {S0, S0, SX, S0}};
    vecs[4]  = '{frame: 16'h1004, blz: 1'b1, an_exp: {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                 seg_exp: {S1, S0, S0, S4}};
    vecs[5]  = '{frame: 16'h9C87, blz: 1'b0, an_exp: {4'b0111, 4'b1111, 4'b1101, 4'b1110},
                 seg_exp: {S9, SX, S8, S7}};
    vecs[6]  = '{frame: 16'h0050, blz: 1'b0, an_exp: {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                 seg_exp: {S0, S0, S5, S0}};
    vec_a    = '{frame: 16'h1357, blz: 1'b0, an_exp: {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                 seg_exp: {S1, S3, S5, S7}};
    vec_b    = '{frame: 16'h2468, blz: 1'b0, an_exp: {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                 seg_exp: {S2, S4, S6, S8}};

    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = 16'h0000;
    blank_lz   = 1'b0;
    repeat (3) tick();
    chk("rst an_n", {28'd0, an_n}, 32'hF);
    chk("rst seg_out", {25'd0, seg_out}, 32'h0);
    chk("rst dec_x", {28'd0, dec_x}, 32'h0);
    chk("rst load_ready", {31'd0, load_ready}, 32'd1);
    chk("rst frame_done", {31'd0, frame_done}, 32'd0);

    rst_n = 1'b1;
    check_frame(zero_vec, "boot");

    n = 0;
    while (frame_done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("frame_done period", n, 31);
    tick();

    for (int i = 0; i < 7; i++) begin
      blank_lz = vecs[i].blz;
      load(vecs[i].frame);
      wait_frame();
      check_frame(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back: B waits for the frame-end cycle that moves A to active.
    blank_lz = 1'b0;
    repeat (3) tick();
    load_valid = 1'b1;
    load_data  = vec_a.frame;
    chk("b2b ready_a", {31'd0, load_ready}, 32'd1);
    tick();
    load_data = vec_b.frame;
    chk("b2b ready_low", {31'd0, load_ready}, 32'd0);
    n = 0;
    while (load_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("b2b wait cycles", n, 27);
    chk("b2b same-cycle xfer", {31'd0, frame_done}, 32'd1);
    tick();
    load_valid = 1'b0;
    chk("b2b b_pending", {31'd0, load_ready}, 32'd0);
    check_frame(vec_a, "b2b_a");
    check_frame(vec_b, "b2b_b");

    // Mid-slot reset with a frame pending.
    load(16'h5555);
    repeat (12) tick();
    chk("pre_rst an_n", {28'd0, an_n}, 32'hD);
    chk("pre_rst load_ready", {31'd0, load_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst an_n", {28'd0, an_n}, 32'hF);
    chk("mid_rst load_ready", {31'd0, load_ready}, 32'd1);
    chk("mid_rst seg_out", {25'd0, seg_out}, 32'h0);
    chk("mid_rst dec_x", {28'd0, dec_x}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    check_frame(zero_vec, "post_rst0");
    check_frame(zero_vec, "post_rst1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
